imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 18 +
 rtl/word_packer.sv | 34 +++
 rtl/imem_loader.sv | 129 ++++++++++++
 tb/tb_imem_loader.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  localparam int unsigned DEPTH_WORDS = 1024;
  localparam int unsigned LEN_W       = 16;
  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned WORD_W      = 32;
  localparam int unsigned BCNT_W      = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    FINISH = 3'd4
  } state_t;

endpackage

// File: rtl/word_packer.sv
// Packs a little-endian byte stream into 32-bit words.
module word_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              byte_en,
  input  logic [BYTE_W-1:0] byte_data,
  output logic              word_done_c,
  output logic [WORD_W-1:0] word_c
);

  localparam int unsigned SHR_W = WORD_W - BYTE_W;

  logic [BCNT_W-1:0] byte_cnt;
  logic [SHR_W-1:0]  shreg;

  // Shift each accepted byte in from the top so byte 0 ends up in the low lane.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      byte_cnt <= '0;
      shreg    <= '0;
    end else if (byte_en) begin
      byte_cnt <= byte_cnt + BCNT_W'(1);
      shreg    <= {byte_data, shreg[SHR_W-1:BYTE_W]};
    end
  end

  // The fourth byte completes the word combinationally with the three held bytes.
  assign word_done_c = byte_en && (byte_cnt == BCNT_W'(3));
  assign word_c      = {byte_data, shreg};

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed program byte stream into instruction memory
// while holding the core in reset.
module imem_loader #(
  parameter int unsigned DEPTH_WORDS = imem_loader_pkg::DEPTH_WORDS,
  parameter int unsigned ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  import imem_loader_pkg::*;

  state_t            state;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  word_cnt;
  logic              byte_fire_c;
  logic              data_fire_c;
  logic              pack_clr_c;
  logic              word_done_c;
  logic [WORD_W-1:0] word_c;
  logic [LEN_W-1:0]  len_c;
  logic [LEN_W-1:0]  word_nxt_c;

  assign byte_fire_c = byte_valid && byte_ready;
  assign data_fire_c = byte_fire_c && (state == DATA);
  assign pack_clr_c  = (state == IDLE) && start;
  assign len_c       = {byte_data, len[BYTE_W-1:0]};
  assign word_nxt_c  = word_cnt + LEN_W'(1);

  word_packer u_packer (
    .clk         (clk),
    .rst         (rst),
    .clr         (pack_clr_c),
    .byte_en     (data_fire_c),
    .byte_data   (byte_data),
    .word_done_c (word_done_c),
    .word_c      (word_c)
  );

  // Session FSM with registered handshake, memory-write and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      byte_ready <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_rst   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      len        <= '0;
      word_cnt   <= '0;
    end else begin
      imem_we <= 1'b0;
      done    <= 1'b0;
      unique case (state)
        IDLE: begin
          // Release the core one cycle after a successful session's done pulse.
          if (done) core_rst <= 1'b0;
          if (start) begin
            state      <= LEN_LO;
            byte_ready <= 1'b1;
            busy       <= 1'b1;
            err        <= 1'b0;
            core_rst   <= 1'b1;
            word_cnt   <= '0;
          end
        end
        LEN_LO: begin
          if (byte_fire_c) begin
            len[BYTE_W-1:0] <= byte_data;
            state           <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (byte_fire_c) begin
            len <= len_c;
            if (len_c == '0) begin
              state      <= FINISH;
              byte_ready <= 1'b0;
            end else if (len_c > LEN_W'(DEPTH_WORDS)) begin
              state      <= IDLE;
              byte_ready <= 1'b0;
              busy       <= 1'b0;
              err        <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (word_done_c) begin
            imem_we    <= 1'b1;
            imem_wdata <= word_c;
            imem_addr  <= ADDR_W'(word_cnt);
            word_cnt   <= word_nxt_c;
            if (word_nxt_c == len) begin
              state      <= FINISH;
              byte_ready <= 1'b0;
            end
          end
        end
        FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state      <= IDLE;
          byte_ready <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as bytes are driven.
module tb_imem_loader;

  localparam int unsigned ADDR_W = 10;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = 8'h00;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_rst;
  logic              busy;
  logic              done;
  logic              err;

  int nchecks = 0;
  int nerrors = 0;
  int cyc = 0;
  int last_we_cyc = 0;
  int we_cnt = 0;
  int done_cnt = 0;

  wr_t        exp_q[$];
  logic [7:0] stim[$];

  imem_loader #(.DEPTH_WORDS(1024), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst   (core_rst),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerrors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Write monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin : mon
    wr_t e;
    if (done === 1'b1) done_cnt++;
    if (imem_we === 1'b1) begin
      we_cnt++;
      last_we_cyc = cyc;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_we", 32'(imem_addr), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check_eq("we_addr", 32'(imem_addr), 32'(e.addr));
        check_eq("we_data", imem_wdata, e.data);
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("start_busy", 32'(busy), 32'd1);
    check_eq("start_ready", 32'(byte_ready), 32'd1);
    check_eq("start_core_rst", 32'(core_rst), 32'd1);
    check_eq("start_err_clr", 32'(err), 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit jitter);
    int guard;
    int gaps;
    guard = 0;
    gaps = jitter ? int'($urandom_range(2, 0)) : 0;
    repeat (gaps) begin
      byte_valid = 1'b0;
      byte_data  = 8'($urandom);
      @(negedge clk);
    end
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!byte_ready) check_eq("byte_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  // Drives stim[], queueing each completed word as its fourth byte is driven.
  task automatic run_session(input bit jitter, input bit expect_write);
    logic [31:0] acc;
    int nd;
    int guard;
    acc = '0;
    pulse_start();
    for (int i = 0; i < stim.size(); i++) begin
      if (i >= 2) begin
        nd = i - 2;
        acc[8*(nd%4) +: 8] = stim[i];
        if (nd % 4 == 3) exp_q.push_back('{addr: ADDR_W'(nd / 4), data: acc});
      end
      send_byte(stim[i], jitter);
    end
    byte_valid = 1'b0;
    guard = 0;
    while (done !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check_eq("done_seen", 32'(done), 32'd1);
    if (expect_write) check_eq("done_gap", 32'(cyc - last_we_cyc), 32'd1);
    check_eq("writes_left", 32'(exp_q.size()), 32'd0);
    check_eq("done_core_rst", 32'(core_rst), 32'd1);
    @(negedge clk);
    check_eq("done_width", 32'(done), 32'd0);
    check_eq("core_rst_fall", 32'(core_rst), 32'd0);
    check_eq("idle_busy", 32'(busy), 32'd0);
    check_eq("idle_ready", 32'(byte_ready), 32'd0);
  endtask

  initial begin
    logic [31:0] w;
    int we0;
    int dn0;

    // Reset, then idle with no start.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_eq("rst_addr", 32'(imem_addr), 32'd0);
    check_eq("rst_wdata", imem_wdata, 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    repeat (20) @(negedge clk);
    check_eq("idle_core_rst", 32'(core_rst), 32'd1);
    check_eq("idle20_busy", 32'(busy), 32'd0);
    check_eq("idle_we", 32'(imem_we), 32'd0);
    check_eq("idle_we_cnt", 32'(we_cnt), 32'd0);

    // Two-word program at one byte per cycle.
    stim = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    run_session(1'b0, 1'b1);
    check_eq("hold_addr", 32'(imem_addr), 32'd1);
    check_eq("hold_wdata", imem_wdata, 32'h0010_0593);

    // Same program with a stuttering byte_valid.
    repeat (3) @(negedge clk);
    run_session(1'b1, 1'b1);

    // Zero-length program.
    we0 = we_cnt;
    stim = '{8'h00, 8'h00};
    run_session(1'b0, 1'b0);
    check_eq("zero_len_writes", 32'(we_cnt - we0), 32'd0);

    // Length 1025 exceeds the memory.
    we0 = we_cnt;
    dn0 = done_cnt;
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h04, 1'b0);
    byte_valid = 1'b0;
    check_eq("len_err", 32'(err), 32'd1);
    check_eq("len_err_busy", 32'(busy), 32'd0);
    check_eq("len_err_ready", 32'(byte_ready), 32'd0);
    repeat (5) @(negedge clk);
    check_eq("len_err_sticky", 32'(err), 32'd1);
    check_eq("len_err_core_rst", 32'(core_rst), 32'd1);
    check_eq("len_err_writes", 32'(we_cnt - we0), 32'd0);
    check_eq("len_err_no_done", 32'(done_cnt - dn0), 32'd0);
    stim = '{8'h00, 8'h00};
    run_session(1'b0, 1'b0);

    // Largest legal program fills every word.
    stim.delete();
    stim.push_back(8'h00);
    stim.push_back(8'h04);
    for (int i = 0; i < 1024; i++) begin
      w = {~16'(i), 16'(i)} ^ 32'h5A3C_0000;
      for (int k = 0; k < 4; k++) stim.push_back(w[8*k +: 8]);
    end
    we0 = we_cnt;
    run_session(1'b0, 1'b1);
    check_eq("full_writes", 32'(we_cnt - we0), 32'd1024);
    check_eq("full_last_addr", 32'(imem_addr), 32'd1023);

    // Reset in the middle of a three-word load.
    we0 = we_cnt;
    pulse_start();
    exp_q.push_back('{addr: ADDR_W'(0), data: 32'h4433_2211});
    stim = '{8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    foreach (stim[i]) send_byte(stim[i], 1'b0);
    byte_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_ready", 32'(byte_ready), 32'd0);
    check_eq("mid_rst_core_rst", 32'(core_rst), 32'd1);
    check_eq("mid_rst_addr", 32'(imem_addr), 32'd0);
    check_eq("mid_rst_wdata", imem_wdata, 32'd0);
    repeat (10) @(negedge clk);
    check_eq("mid_rst_writes", 32'(we_cnt - we0), 32'd1);
    check_eq("mid_rst_q", 32'(exp_q.size()), 32'd0);
    check_eq("mid_rst_core_hold", 32'(core_rst), 32'd1);
    stim = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_session(1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
    $finish;
  end

endmodule
